// File: rtl/mem_resp_pkg.sv
// Shared types and widths for the S1 core memory responder.
package mem_resp_pkg;

  localparam int unsigned WORD_ADDR_W = 30;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned MASK_W      = DATA_W / 8;
  localparam int unsigned WDOG_W      = 16;

  localparam logic [DATA_W-1:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_RESET,
    S_IFETCH,
    S_DDEC,
    S_DACC,
    S_STEP
  } state_e;

endpackage

// File: rtl/mem_resp_watchdog.sv
// Counts unacknowledged request cycles and flags the cycle the limit is reached.
module mem_resp_watchdog
  import mem_resp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              count_en_i,
  input  logic [WDOG_W-1:0] limit_i,
  output logic              timeout_c_o
);

  logic [WDOG_W-1:0] cnt_q;
  logic [WDOG_W-1:0] cnt_d;

  // The current waiting cycle is the limit-th one when cnt_q == limit-1.
  assign timeout_c_o = count_en_i && (cnt_q == (limit_i - WDOG_W'(1)));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || timeout_c_o) begin
      cnt_d = '0;
    end else if (count_en_i) begin
      cnt_d = cnt_q + WDOG_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/core_mem_responder.sv
// Sequences instruction fetch and data access for the S1 core over one shared
// memory port and issues one clk_en pulse per completed core step.
module core_mem_responder
  import mem_resp_pkg::*;
#(
  parameter logic [DATA_W-1:0] NOP_INST    = NOP,
  parameter int unsigned       ACK_TIMEOUT = 64,
  parameter logic [DATA_W-1:0] ERR_RDATA   = 32'hFFFF_FFFF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WORD_ADDR_W-1:0] core_inst_addr,
  input  logic                   core_req_raw,
  input  logic                   core_we_raw,
  input  logic [MASK_W-1:0]      core_mask,
  input  logic [DATA_W-1:0]      core_wdata,
  input  logic [WORD_ADDR_W-1:0] core_data_addr,
  output logic [DATA_W-1:0]      core_inst,
  output logic [DATA_W-1:0]      core_rdata,
  output logic                   core_clk_en,
  output logic                   bm_req,
  output logic                   bm_we,
  output logic [WORD_ADDR_W-1:0] bm_addr,
  output logic [MASK_W-1:0]      bm_wmask,
  output logic [DATA_W-1:0]      bm_wdata,
  input  logic [DATA_W-1:0]      bm_rdata,
  input  logic                   bm_ack,
  output logic                   bus_err
);

  state_e            state_q;
  logic [DATA_W-1:0] core_inst_q;
  logic [DATA_W-1:0] core_rdata_q;
  logic              clk_en_q;
  logic              bus_err_q;
  logic              timeout_c;

  assign core_inst   = core_inst_q;
  assign core_rdata  = core_rdata_q;
  assign core_clk_en = clk_en_q;
  assign bus_err     = bus_err_q;

  // Memory request decode; write fields are zero whenever no request is active.
  always_comb begin
    bm_req   = 1'b0;
    bm_we    = 1'b0;
    bm_addr  = '0;
    bm_wmask = '0;
    bm_wdata = '0;
    case (state_q)
      S_IFETCH: begin
        bm_req  = 1'b1;
        bm_addr = core_inst_addr;
      end
      S_DACC: begin
        bm_req   = 1'b1;
        bm_we    = core_we_raw;
        bm_addr  = core_data_addr;
        bm_wmask = core_mask;
        bm_wdata = core_wdata;
      end
      default: ;
    endcase
  end

  mem_resp_watchdog u_watchdog (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (!bm_req || bm_ack),
    .count_en_i  (bm_req && !bm_ack),
    .limit_i     (WDOG_W'(ACK_TIMEOUT)),
    .timeout_c_o (timeout_c)
  );

  // Step sequencer; a timeout completes the access as if acked, ack wins a tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_RESET;
      core_inst_q  <= NOP_INST;
      core_rdata_q <= '0;
      clk_en_q     <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      clk_en_q <= 1'b0;
      case (state_q)
        S_RESET: state_q <= S_IFETCH;
        S_IFETCH: begin
          if (bm_ack) begin
            core_inst_q <= bm_rdata;
            state_q     <= S_DDEC;
          end else if (timeout_c) begin
            core_inst_q <= NOP_INST;
            bus_err_q   <= 1'b1;
            state_q     <= S_DDEC;
          end
        end
        S_DDEC: begin
          if (core_req_raw) begin
            state_q <= S_DACC;
          end else begin
            state_q  <= S_STEP;
            clk_en_q <= 1'b1;
          end
        end
        S_DACC: begin
          if (bm_ack || timeout_c) begin
            if (!core_we_raw) begin
              core_rdata_q <= bm_ack ? bm_rdata : ERR_RDATA;
            end
            if (!bm_ack) begin
              bus_err_q <= 1'b1;
            end
            state_q  <= S_STEP;
            clk_en_q <= 1'b1;
          end
        end
        S_STEP:  state_q <= S_IFETCH;
        default: state_q <= S_RESET;
      endcase
    end
  end

endmodule

// File: tb/tb_core_mem_responder.sv
// Randomized step-level bench for core_mem_responder with a behavioural memory.
module tb_core_mem_responder;

  localparam int unsigned T     = 8;
  localparam int          NOACK = 1000;
  localparam logic [31:0] NOP_I = 32'h0000_0013;
  localparam logic [31:0] ERR_D = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [29:0] core_inst_addr = '0;
  logic        core_req_raw = 1'b0;
  logic        core_we_raw = 1'b0;
  logic [3:0]  core_mask = '0;
  logic [31:0] core_wdata = '0;
  logic [29:0] core_data_addr = '0;
  logic [31:0] core_inst, core_rdata;
  logic        core_clk_en;
  logic        bm_req, bm_we;
  logic [29:0] bm_addr;
  logic [3:0]  bm_wmask;
  logic [31:0] bm_wdata;
  logic [31:0] bm_rdata = '0;
  logic        bm_ack;
  logic        bus_err;
  logic        mem_ack = 1'b0;
  logic        late_ack = 1'b0;

  assign bm_ack = mem_ack | late_ack;

  core_mem_responder #(.ACK_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .core_inst_addr(core_inst_addr), .core_req_raw(core_req_raw),
    .core_we_raw(core_we_raw), .core_mask(core_mask),
    .core_wdata(core_wdata), .core_data_addr(core_data_addr),
    .core_inst(core_inst), .core_rdata(core_rdata), .core_clk_en(core_clk_en),
    .bm_req(bm_req), .bm_we(bm_we), .bm_addr(bm_addr), .bm_wmask(bm_wmask),
    .bm_wdata(bm_wdata), .bm_rdata(bm_rdata), .bm_ack(bm_ack), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem     [512];
  logic [31:0] ref_mem [512];

  // Current step as seen by the memory model and the reference.
  int          fw, dw, req_idx;
  int          cur_ia, cur_da;
  logic        cur_we;
  logic [3:0]  cur_mask;
  logic [31:0] cur_wd;
  int          exp_period, exp_reqs;
  logic [31:0] exp_inst, exp_rdata;
  logic        exp_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int acc_cycles(input int w);
    return (w >= int'(T)) ? int'(T) : w + 1;
  endfunction

  function automatic int pick_wait();
    int r;
    r = int'($urandom_range(0, 11));
    if (r < 9) return r % 4;
    if (r == 9) return int'(T) - 1;
    if (r == 10) return int'(T) - 2;
    return NOACK;
  endfunction

  // Behavioural memory: per-request wait states, byte-masked writes.
  int   wcnt = 0;
  logic in_req = 1'b0;
  always @(negedge clk) begin
    int cw;
    int idx;
    if (bm_req) begin
      if (!in_req) begin
        in_req = 1'b1;
        wcnt = 0;
        req_idx++;
        if (req_idx == 1) begin
          check_eq("fetch_addr", 32'(bm_addr), 32'(cur_ia));
          check_eq("fetch_we", 32'(bm_we), 32'(0));
        end else begin
          check_eq("data_addr", 32'(bm_addr), 32'(cur_da));
          check_eq("data_we", 32'(bm_we), 32'(cur_we));
          if (cur_we) begin
            check_eq("data_wmask", 32'(bm_wmask), 32'(cur_mask));
            check_eq("data_wdata", bm_wdata, cur_wd);
          end
        end
      end
      cw = (req_idx == 1) ? fw : dw;
      if (wcnt == cw) begin
        mem_ack = 1'b1;
        idx = int'(bm_addr[8:0]);
        if (bm_we) begin
          for (int b = 0; b < 4; b++)
            if (bm_wmask[b]) mem[idx][8*b +: 8] = bm_wdata[8*b +: 8];
          bm_rdata = $urandom;
        end else begin
          bm_rdata = mem[idx];
        end
        in_req = 1'b0;
      end else begin
        mem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      mem_ack = 1'b0;
      in_req = 1'b0;
      check_eq("idle_we_mask", 32'({bm_we, bm_wmask}), 32'(0));
      check_eq("idle_wdata", bm_wdata, 32'(0));
    end
  end

  // Drive one core step and predict its outcome from the access rules.
  task automatic set_step(input int ia, input logic rq, input logic we, input logic [3:0] mk,
                          input logic [31:0] wd, input int da, input int fwait, input int dwait);
    core_inst_addr = 30'(ia);
    core_req_raw   = rq;
    core_we_raw    = we;
    core_mask      = mk;
    core_wdata     = wd;
    core_data_addr = 30'(da);
    cur_ia = ia; cur_da = da; cur_we = we; cur_mask = mk; cur_wd = wd;
    fw = fwait; dw = dwait;
    req_idx = 0;
    exp_reqs = rq ? 2 : 1;
    exp_period = acc_cycles(fwait) + 2 + (rq ? acc_cycles(dwait) : 0);
    if (fwait >= int'(T)) begin
      exp_inst = NOP_I;
      exp_err = 1'b1;
    end else begin
      exp_inst = ref_mem[ia];
    end
    if (rq) begin
      if (dwait >= int'(T)) begin
        exp_err = 1'b1;
        if (!we) exp_rdata = ERR_D;
      end else if (we) begin
        for (int b = 0; b < 4; b++)
          if (mk[b]) ref_mem[da][8*b +: 8] = wd[8*b +: 8];
      end else begin
        exp_rdata = ref_mem[da];
      end
    end
  endtask

  task automatic wait_step(input string tag);
    int cyc;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!core_clk_en && cyc < 100);
    check_eq({tag, "_period"}, 32'(cyc), 32'(exp_period));
    check_eq({tag, "_inst"}, core_inst, exp_inst);
    check_eq({tag, "_rdata"}, core_rdata, exp_rdata);
    check_eq({tag, "_bus_err"}, 32'(bus_err), 32'(exp_err));
    check_eq({tag, "_nreq"}, 32'(req_idx), 32'(exp_reqs));
  endtask

  task automatic random_step();
    logic rq;
    rq = 1'($urandom_range(0, 1));
    set_step(int'($urandom_range(0, 511)), rq, 1'($urandom_range(0, 1)), 4'($urandom),
             $urandom, int'($urandom_range(0, 511)), pick_wait(), pick_wait());
    wait_step("rand");
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = $urandom;
    mem[0] = 32'h0000_0093;
    mem[9'h100] = 32'hDEAD_BEEF;
    for (int i = 0; i < 512; i++) ref_mem[i] = mem[i];
    exp_rdata = '0;
    exp_err = 1'b0;

    repeat (3) @(negedge clk);
    check_eq("rst_inst", core_inst, NOP_I);
    check_eq("rst_rdata", core_rdata, 32'(0));
    check_eq("rst_clk_en", 32'(core_clk_en), 32'(0));
    check_eq("rst_bm_req", 32'(bm_req), 32'(0));
    check_eq("rst_bus_err", 32'(bus_err), 32'(0));

    set_step(0, 1'b0, 1'b0, 4'h0, 32'h0, 0, 0, 0);
    rst = 1'b0;
    wait_step("first");
    set_step(1, 1'b1, 1'b0, 4'h0, 32'h0, 9'h100, 0, 2);
    wait_step("load");
    set_step(2, 1'b1, 1'b1, 4'b0110, 32'h1234_5678, 9'h40, 0, 0);
    wait_step("store");
    set_step(3, 1'b1, 1'b0, 4'h0, 32'h0, 9'h40, 1, int'(T) - 1);
    wait_step("ack_at_limit");
    set_step(4, 1'b0, 1'b0, 4'h0, 32'h0, 0, NOACK, 0);
    wait_step("fetch_timeout");
    set_step(5, 1'b0, 1'b0, 4'h0, 32'h0, 0, 0, 0);
    wait_step("sticky");

    for (int n = 0; n < 40; n++) random_step();

    // Reset while a data read is outstanding.
    set_step(6, 1'b1, 1'b0, 4'h0, 32'h0, 7, 0, NOACK);
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (req_idx == 2 && bm_req) break;
    end
    check_eq("pre_rst_in_dacc", 32'(req_idx == 2 && bm_req), 32'(1));
    rst = 1'b1;
    late_ack = 1'b1;
    #1;
    check_eq("mid_rst_bm_req", 32'(bm_req), 32'(0));
    check_eq("mid_rst_clk_en", 32'(core_clk_en), 32'(0));
    repeat (3) @(negedge clk);
    check_eq("late_ack_inst", core_inst, NOP_I);
    check_eq("late_ack_rdata", core_rdata, 32'(0));
    check_eq("late_ack_bus_err", 32'(bus_err), 32'(0));
    exp_rdata = '0;
    exp_err = 1'b0;
    set_step(8, 1'b0, 1'b0, 4'h0, 32'h0, 0, 1, 0);
    rst = 1'b0;
    late_ack = 1'b0;
    wait_step("restart");

    for (int n = 0; n < 15; n++) random_step();

    for (int i = 0; i < 512; i++) check_eq("mem_image", mem[i], ref_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit got=running exp=finished");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/core_mem_responder.md
Name: core_mem_responder

Overview:
- Memory-side responder for the S1 core.
- Serves the core's instruction port (inst_addr / inst_in) and data port (data_addr / mem_req / mem_we / mask / data_out / data_in) from one shared single-port backing memory with a req/ack handshake.
- Generates the core's clk_en. The core advances exactly one step per clk_en pulse, and only after the instruction fetch and any data access for that step are complete.
- Sits between toplevel and the SoC memory/bus.

Parameters:
- NOP_INST, 32'h0000_0013, value of inst_in after reset (addi x0,x0,0).
- ACK_TIMEOUT, 64, cycles bm_req may wait for bm_ack before the access is aborted; legal range 2..65535.
- ERR_RDATA, 32'hFFFF_FFFF, data returned to the core on a timed-out read.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- core_inst_addr  in  30  core instruction word address
- core_req_raw  in  1  core data request, before clk_en qualification
- core_we_raw  in  1  core data write, before clk_en qualification
- core_mask  in  4  byte-lane write mask
- core_wdata  in  32  core store data (data_out)
- core_data_addr  in  30  core data word address
- core_inst  out  32  instruction word to core (inst_in), registered
- core_rdata  out  32  load data to core (data_in), registered
- core_clk_en  out  1  core step enable
- bm_req  out  1  backing memory request
- bm_we  out  1  backing memory write
- bm_addr  out  30  backing memory word address
- bm_wmask  out  4  backing memory byte mask
- bm_wdata  out  32  backing memory write data
- bm_rdata  in  32  backing memory read data, valid with bm_ack
- bm_ack  in  1  backing memory completion
- bus_err  out  1  sticky timeout flag

Behaviour:
- Reset values (asynchronous):
  - state = S_RESET
  - core_inst = NOP_INST, core_rdata = 0, core_clk_en = 0
  - bm_req = 0, bus_err = 0, watchdog = 0
  - Asserting rst mid-access drops bm_req immediately. Any ack arriving later is ignored.
- State machine:
  - S_RESET: all requests idle. Next state S_IFETCH (the first cycle after rst deasserts).
  - S_IFETCH:
    - Drives bm_req=1, bm_we=0, bm_addr=core_inst_addr.
    - On bm_ack: core_inst <= bm_rdata, go to S_DDEC.
  - S_DDEC:
    - One idle cycle (bm_req=0) so the core's combinational data path settles on the new core_inst.
    - Samples core_req_raw: if 1, go to S_DACC; else go to S_STEP.
  - S_DACC:
    - Drives bm_req=1, bm_we=core_we_raw, bm_addr=core_data_addr, bm_wmask=core_mask, bm_wdata=core_wdata.
    - On bm_ack: if it is a read, core_rdata <= bm_rdata. Then go to S_STEP.
  - S_STEP:
    - core_clk_en=1 for exactly this cycle. Next state S_IFETCH.
- bm_* outputs are combinational from state and core inputs. Core inputs are stable while core_clk_en=0.
- bm_req deasserts the cycle after ack. When bm_req=0, bm_we, bm_wmask and bm_wdata are forced to 0.
- bm_ack is ignored in S_RESET, S_DDEC and S_STEP.
- An ack in the first request cycle is legal (zero-wait).
- Step period with zero-wait memory: 3 cycles without a data access, 4 cycles with one. Each memory wait state adds 1 cycle.
- A write with core_mask=0 is still issued to memory; the lanes are left to memory semantics.
- Watchdog:
  - Counts cycles with bm_req=1 and bm_ack=0; clears on ack or on leaving the request state.
  - When the count reaches ACK_TIMEOUT: abort the access, set bus_err=1 (sticky until rst), and advance as if acked.
  - On an aborted fetch, core_inst <= NOP_INST. On an aborted read, core_rdata <= ERR_RDATA. On an aborted write, no data update.
  - An ack coinciding with timeout counts as an ack: the data is taken and bus_err is not set.
- core_rdata is held unchanged across steps that have no load.

Decomposition:
- Package mem_resp_pkg contains:
  - state enum {S_RESET, S_IFETCH, S_DDEC, S_DACC, S_STEP}
  - NOP constant
  - width localparams (WORD_ADDR_W=30, DATA_W=32)
- One sub-module: mem_resp_watchdog. It holds the counter with inputs clear, count_en, and limit, and outputs a timeout pulse.

Test Plan:
- Reset, then release with zero-wait memory returning 0x0000_0093 at addr 0: core_inst=0x13 during reset; then bm_req high with bm_addr=0; core_inst=0x93 next cycle; core_clk_en pulses 3 cycles after release; steps are spaced every 3 cycles.
- Load with core_req_raw=1, core_we_raw=0, data_addr=0x100, memory returns 0xDEADBEEF with 2 wait states: bm_addr=0x100 in S_DACC; core_rdata=0xDEADBEEF before the clk_en pulse; step period is 6 cycles.
- Store with mask=4'b0110, wdata=0x12345678, addr=0x40: bm_we=1, bm_wmask=0110, bm_wdata=0x12345678 for one cycle; core_rdata unchanged.
- No ack, ACK_TIMEOUT=8, on fetch: bm_req stays high for 8 cycles, then drops; bus_err=1; core_inst=NOP_INST; the step still occurs; bus_err persists.
- Ack coinciding with the timeout cycle on a read: data is latched and bus_err stays 0.
- rst asserted while in S_DACC with bm_req high: bm_req=0 and core_clk_en=0 immediately; the sequence restarts with a fetch after release; a late ack has no effect.
